frame_write_sequencer: RTL and testbench
========================================

// Module: frame_write_sequencer
// PURPOSE
//  Sequences writes into a tile's frame-latch configuration memory. Accepts one (frame index, frame word)
//  command per valid/ready handshake, drives FrameData, then pulses exactly one FrameStrobe bit with
//  programmable setup/strobe/hold spacing so the level-sensitive latches capture cleanly. Sits between the
//  bitstream loader and the per-column FrameData/FrameStrobe nets of the tile ConfigMem instances.
// PARAMETERS
//  FrameBitsPerRow  32  width of a frame word / FrameData bus
//  MaxFramesPerCol  20  number of FrameStrobe lines; legal frame index 0..MaxFramesPerCol-1
//  FrameIdxW        5   width of wr_frame; must satisfy 2**FrameIdxW >= MaxFramesPerCol
//  SETUP_CYCLES     1   cycles FrameData is stable before strobe rises (>=1)
//  STROBE_CYCLES    2   cycles strobe is held high (>=1)
//  HOLD_CYCLES      1   cycles FrameData is held after strobe falls (>=1)
// PORTS
//  CLK          in   1                system clock, all state on rising edge
//  resetn       in   1                synchronous active-low reset, one clock; resetn is synchronous and active-low
//  wr_valid     in   1                command valid
//  wr_ready     out  1                sequencer can accept a command
//  wr_frame     in   FrameIdxW        target frame (strobe line) index
//  wr_data      in   FrameBitsPerRow  frame word to write
//  clr_err      in   1                clears err_range
//  FrameData    out  FrameBitsPerRow  registered frame word to latches
//  FrameStrobe  out  MaxFramesPerCol  registered one-hot latch enable
//  busy         out  1                ~wr_ready while out of reset
//  err_range    out  1                sticky: an out-of-range wr_frame was received
//  frame_count  out  16               strobes completed, wraps 0xFFFF->0
// BEHAVIOUR
//  Reset (resetn=0 at an edge): state=IDLE, FrameData=0, FrameStrobe=0, err_range=0, frame_count=0,
//   wr_ready=0 while resetn=0, busy=0. Reset mid-sequence aborts at that edge: strobe drops immediately
//   (registered), and no count increment occurs.
//  FSM states IDLE, SETUP, STROBE, HOLD. Down-counter cnt is loaded with (N-1) on entering each timed state.
//  IDLE: wr_ready=1. On wr_valid&wr_ready:
//   - wr_frame < MaxFramesPerCol: capture wr_data->FrameData and wr_frame->idx, go to SETUP.
//   - otherwise: set err_range, leave FrameData unchanged, stay IDLE (wr_ready stays 1), no strobe.
//  SETUP: SETUP_CYCLES cycles, FrameStrobe=0; the exit edge goes to STROBE and sets FrameStrobe[idx]=1.
//  STROBE: FrameStrobe one-hot at idx for exactly STROBE_CYCLES cycles. The exit edge clears the strobe,
//   increments frame_count and goes to HOLD.
//  HOLD: HOLD_CYCLES cycles, FrameStrobe=0, FrameData held. The exit edge goes to IDLE.
//  Timing: with the accept edge as edge 0, the strobe is high from edge SETUP to edge SETUP+STROBE.
//   wr_ready rises at edge SETUP+STROBE+HOLD. Throughput is one command per SETUP+STROBE+HOLD+1 cycles.
//   Defaults: 5 cycles/frame.
//  FrameData changes only on an accept edge, and stays held in IDLE until the next valid accept.
//  FrameStrobe is never multi-hot and is never high outside STROBE.
//  wr_frame/wr_data are ignored when wr_ready=0. Input stability is not required while wr_ready=0.
//  clr_err together with a new range error in the same cycle: the error wins (err_range=1).
//  frame_count uses 16-bit modulo arithmetic.
// TESTING
//  1 Reset then idle: after resetn low 2 cycles -> FrameStrobe=0, FrameData=0, wr_ready=1 at first cycle
//    after release, frame_count=0.
//  2 Single write frame=3, data=0xA5A5_F00F, defaults -> FrameData=0xA5A5_F00F from edge 1.
//    FrameStrobe=0x00008 high exactly cycles 2-3, wr_ready high again at edge 4, frame_count=1.
//  3 Back-to-back valid held high, frames 0..19, data=i*0x0101_0101 -> 20 strobes each 2 cycles wide,
//    one per 5 cycles, each one-hot at index i; data stable 1 cycle before/after each; frame_count=20.
//  4 wr_frame=20 and then 31 -> err_range=1, no strobe, FrameData unchanged, wr_ready stays 1.
//    clr_err -> err_range=0; clr_err with frame=25 in the same cycle -> err_range=1.
//  5 SETUP=3,STROBE=4,HOLD=2, frame=19 -> strobe bit19 high edges 3..7, ready at edge 9.
//    resetn pulsed low during STROBE -> strobe 0 next edge, count unchanged.
//  6 frame_count preload near wrap (force 0xFFFF) then one write -> frame_count=0x0000.

Source files
------------

// File: rtl/frame_write_sequencer.sv
// rtl/frame_write_sequencer.sv - frame-latch write sequencer with setup/strobe/hold spacing
module frame_write_sequencer #(
    parameter int FrameBitsPerRow = 32,
    parameter int MaxFramesPerCol = 20,
    parameter int FrameIdxW       = 5,
    parameter int SETUP_CYCLES    = 1,
    parameter int STROBE_CYCLES   = 2,
    parameter int HOLD_CYCLES     = 1
) (
    input  logic                       CLK,
    input  logic                       resetn,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [FrameIdxW-1:0]       wr_frame,
    input  logic [FrameBitsPerRow-1:0] wr_data,
    input  logic                       clr_err,
    output logic [FrameBitsPerRow-1:0] FrameData,
    output logic [MaxFramesPerCol-1:0] FrameStrobe,
    output logic                       busy,
    output logic                       err_range,
    output logic [15:0]                frame_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    // Each timed state counts down from N-1 to 0; the edge seen at 0 is the exit edge.
    localparam logic [15:0] SETUP_LD  = 16'(SETUP_CYCLES - 1);
    localparam logic [15:0] STROBE_LD = 16'(STROBE_CYCLES - 1);
    localparam logic [15:0] HOLD_LD   = 16'(HOLD_CYCLES - 1);
    localparam logic [MaxFramesPerCol-1:0] STROBE_ONE = {{(MaxFramesPerCol-1){1'b0}}, 1'b1};

    state_t                       state_q, state_d;
    logic [15:0]                  cnt_q, cnt_d;
    logic [FrameBitsPerRow-1:0]   data_q, data_d;
    logic [FrameIdxW-1:0]         idx_q, idx_d;
    logic [MaxFramesPerCol-1:0]   strobe_q, strobe_d;
    logic                         err_q, err_d;
    logic [15:0]                  frame_count_q, frame_count_d;
    logic                         accept;
    logic                         in_range;
    logic                         cnt_done;

    assign in_range = (32'(wr_frame) < 32'(MaxFramesPerCol));
    assign cnt_done = (cnt_q == 16'd0);

    // State register; reset aborts any sequence in progress at the reset edge.
    always_ff @(posedge CLK) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: out-of-range commands are consumed but leave the FSM in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && in_range) state_d = SETUP;
            SETUP:   if (cnt_done)           state_d = STROBE;
            STROBE:  if (cnt_done)           state_d = HOLD;
            HOLD:    if (cnt_done)           state_d = IDLE;
            default:                         state_d = IDLE;
        endcase
    end

    // Outputs and datapath next values; strobe is set/cleared only on timed-state exit edges.
    always_comb begin
        wr_ready      = resetn && (state_q == IDLE);
        busy          = resetn && (state_q != IDLE);
        accept        = wr_valid && wr_ready;
        cnt_d         = cnt_q;
        data_d        = data_q;
        idx_d         = idx_q;
        strobe_d      = strobe_q;
        err_d         = err_q && !clr_err;
        frame_count_d = frame_count_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (in_range) begin
                        data_d = wr_data;
                        idx_d  = wr_frame;
                        cnt_d  = SETUP_LD;
                    end else begin
                        err_d  = 1'b1;
                    end
                end
            end
            SETUP: begin
                if (cnt_done) begin
                    strobe_d = STROBE_ONE << idx_q;
                    cnt_d    = STROBE_LD;
                end else begin
                    cnt_d    = cnt_q - 16'd1;
                end
            end
            STROBE: begin
                if (cnt_done) begin
                    strobe_d      = '0;
                    frame_count_d = frame_count_q + 16'd1;
                    cnt_d         = HOLD_LD;
                end else begin
                    cnt_d         = cnt_q - 16'd1;
                end
            end
            HOLD: begin
                if (!cnt_done) begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                strobe_d = '0;
            end
        endcase
    end

    // Datapath registers driving the latch nets.
    always_ff @(posedge CLK) begin
        if (!resetn) begin
            cnt_q         <= '0;
            data_q        <= '0;
            idx_q         <= '0;
            strobe_q      <= '0;
            err_q         <= 1'b0;
            frame_count_q <= '0;
        end else begin
            cnt_q         <= cnt_d;
            data_q        <= data_d;
            idx_q         <= idx_d;
            strobe_q      <= strobe_d;
            err_q         <= err_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign FrameData   = data_q;
    assign FrameStrobe = strobe_q;
    assign err_range   = err_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_frame_write_sequencer.sv
// tb/tb_frame_write_sequencer.sv - scoreboard bench for frame_write_sequencer
module tb_frame_write_sequencer;

    localparam int FB = 32;
    localparam int MF = 20;
    localparam int IW = 5;

    logic          CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic          resetn, wr_valid, wr_ready, clr_err, busy, err_range;
    logic [IW-1:0] wr_frame;
    logic [FB-1:0] wr_data, FrameData;
    logic [MF-1:0] FrameStrobe;
    logic [15:0]   frame_count;

    logic          resetn2, wr_valid2, wr_ready2, clr_err2, busy2, err_range2;
    logic [IW-1:0] wr_frame2;
    logic [FB-1:0] wr_data2, FrameData2;
    logic [MF-1:0] FrameStrobe2;
    logic [15:0]   frame_count2;

    frame_write_sequencer dut (
        .CLK(CLK), .resetn(resetn), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_frame(wr_frame), .wr_data(wr_data), .clr_err(clr_err),
        .FrameData(FrameData), .FrameStrobe(FrameStrobe), .busy(busy),
        .err_range(err_range), .frame_count(frame_count)
    );

    frame_write_sequencer #(
        .SETUP_CYCLES(3), .STROBE_CYCLES(4), .HOLD_CYCLES(2)
    ) dut2 (
        .CLK(CLK), .resetn(resetn2), .wr_valid(wr_valid2), .wr_ready(wr_ready2),
        .wr_frame(wr_frame2), .wr_data(wr_data2), .clr_err(clr_err2),
        .FrameData(FrameData2), .FrameStrobe(FrameStrobe2), .busy(busy2),
        .err_range(err_range2), .frame_count(frame_count2)
    );

    typedef struct {
        logic [IW-1:0] idx;
        logic [FB-1:0] data;
    } exp_t;

    exp_t sb_q[$];
    exp_t cur;
    int   total  = 0;
    int   passed = 0;

    function automatic logic [MF-1:0] oh(input logic [IW-1:0] i);
        logic [MF-1:0] one;
        one = 1;
        return one << i;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Issue one command at a negedge; returns at the negedge after its accept edge.
    task automatic send(input logic [IW-1:0] f, input logic [FB-1:0] d, output time acc_t);
        int n;
        exp_t e;
        wr_valid = 1'b1;
        wr_frame = f;
        wr_data  = d;
        if (f < MF) begin
            e.idx  = f;
            e.data = d;
            sb_q.push_back(e);
        end
        n = 0;
        while (!wr_ready && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 50) check("accept_timeout", 64'd0, 64'd1);
        @(posedge CLK);
        acc_t = $time;
        @(negedge CLK);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!wr_ready && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 50) check("idle_timeout", 64'd0, 64'd1);
    endtask

    // Monitor: pop expected frame at each strobe rise, check width and data hold.
    initial begin
        logic [MF-1:0] prev;
        int            width;
        prev  = '0;
        width = 0;
        forever begin
            @(negedge CLK);
            if (!resetn) begin
                prev  = '0;
                width = 0;
            end else begin
                if (FrameStrobe != '0 && prev == '0) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_strobe", 64'(FrameStrobe), 64'd0);
                    end else begin
                        cur = sb_q.pop_front();
                        check("strobe_onehot", 64'(FrameStrobe), 64'(oh(cur.idx)));
                        check("strobe_data", 64'(FrameData), 64'(cur.data));
                    end
                    width = 1;
                end else if (FrameStrobe != '0) begin
                    width++;
                    check("strobe_stable", 64'(FrameStrobe), 64'(oh(cur.idx)));
                end else if (prev != '0) begin
                    check("strobe_width", 64'(width), 64'd2);
                    check("hold_data", 64'(FrameData), 64'(cur.data));
                end
                prev = FrameStrobe;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        time t, t_prev;
        resetn = 1'b0; wr_valid = 1'b0; wr_frame = '0; wr_data = '0; clr_err = 1'b0;
        resetn2 = 1'b0; wr_valid2 = 1'b0; wr_frame2 = '0; wr_data2 = '0; clr_err2 = 1'b0;
        t_prev = 0;

        // Reset then idle
        repeat (2) @(negedge CLK);
        check("reset_ready", 64'(wr_ready), 64'd0);
        check("reset_strobe", 64'(FrameStrobe), 64'd0);
        check("reset_data", 64'(FrameData), 64'd0);
        check("reset_count", 64'(frame_count), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_err", 64'(err_range), 64'd0);
        resetn = 1'b1;
        resetn2 = 1'b1;
        #1;
        check("ready_after_reset", 64'(wr_ready), 64'd1);

        // Single write, cycle-exact timing
        @(negedge CLK);
        send(5'd3, 32'hA5A5_F00F, t);
        wr_valid = 1'b0;
        for (int k = 0; k <= 4; k++) begin
            check($sformatf("single_strobe_e%0d", k), 64'(FrameStrobe),
                  (k == 1 || k == 2) ? 64'h8 : 64'd0);
            check($sformatf("single_ready_e%0d", k), 64'(wr_ready), (k == 4) ? 64'd1 : 64'd0);
            check($sformatf("single_data_e%0d", k), 64'(FrameData), 64'hA5A5_F00F);
            @(negedge CLK);
        end
        check("single_count", 64'(frame_count), 64'd1);

        // Back-to-back frames 0..19
        for (int i = 0; i < 20; i++) begin
            send(5'(i), 32'(i) * 32'h0101_0101, t);
            if (i > 0) check($sformatf("throughput_%0d", i), 64'(t - t_prev), 64'd50);
            t_prev = t;
        end
        wr_valid = 1'b0;
        wait_idle();
        @(negedge CLK);
        check("b2b_count", 64'(frame_count), 64'd21);
        check("b2b_scoreboard_empty", 64'(sb_q.size()), 64'd0);

        // Range errors and clr_err priority
        send(5'd20, 32'hDEAD_BEEF, t);
        check("err20_flag", 64'(err_range), 64'd1);
        check("err20_ready", 64'(wr_ready), 64'd1);
        check("err20_data", 64'(FrameData), 64'h1313_1313);
        check("err20_strobe", 64'(FrameStrobe), 64'd0);
        send(5'd31, 32'hCAFE_0001, t);
        check("err31_flag", 64'(err_range), 64'd1);
        check("err31_ready", 64'(wr_ready), 64'd1);
        check("err31_data", 64'(FrameData), 64'h1313_1313);
        wr_valid = 1'b0;
        clr_err  = 1'b1;
        @(negedge CLK);
        clr_err = 1'b0;
        check("clr_err", 64'(err_range), 64'd0);
        clr_err = 1'b1;
        send(5'd25, 32'h0BAD_0BAD, t);
        clr_err  = 1'b0;
        wr_valid = 1'b0;
        check("clr_vs_err", 64'(err_range), 64'd1);
        repeat (3) @(negedge CLK);
        check("err_no_count", 64'(frame_count), 64'd21);
        check("err_no_strobe", 64'(FrameStrobe), 64'd0);

        // Counter wrap
        force dut.frame_count_q = 16'hFFFF;
        @(negedge CLK);
        release dut.frame_count_q;
        check("preload_count", 64'(frame_count), 64'hFFFF);
        send(5'd7, 32'h0000_1234, t);
        wr_valid = 1'b0;
        wait_idle();
        check("wrap_count", 64'(frame_count), 64'd0);
        check("wrap_scoreboard_empty", 64'(sb_q.size()), 64'd0);

        // Non-default spacing: SETUP=3 STROBE=4 HOLD=2
        @(negedge CLK);
        wr_valid2 = 1'b1; wr_frame2 = 5'd19; wr_data2 = 32'h5555_AAAA;
        @(posedge CLK);
        @(negedge CLK);
        wr_valid2 = 1'b0;
        for (int k = 0; k <= 10; k++) begin
            check($sformatf("slow_strobe_e%0d", k), 64'(FrameStrobe2),
                  (k >= 3 && k <= 6) ? 64'h8_0000 : 64'd0);
            check($sformatf("slow_ready_e%0d", k), 64'(wr_ready2), (k >= 9) ? 64'd1 : 64'd0);
            @(negedge CLK);
        end
        check("slow_data", 64'(FrameData2), 64'h5555_AAAA);
        check("slow_count", 64'(frame_count2), 64'd1);

        // Reset during STROBE aborts the write
        wr_valid2 = 1'b1; wr_frame2 = 5'd19; wr_data2 = 32'h1111_2222;
        @(posedge CLK);
        @(negedge CLK);
        wr_valid2 = 1'b0;
        repeat (4) @(negedge CLK);
        check("abort_strobe_high", 64'(FrameStrobe2), 64'h8_0000);
        resetn2 = 1'b0;
        @(negedge CLK);
        check("abort_strobe_low", 64'(FrameStrobe2), 64'd0);
        check("abort_ready", 64'(wr_ready2), 64'd0);
        check("abort_count", 64'(frame_count2), 64'd0);
        resetn2 = 1'b1;
        #1;
        check("abort_ready_release", 64'(wr_ready2), 64'd1);
        repeat (6) @(negedge CLK);
        check("abort_no_late_strobe", 64'(FrameStrobe2), 64'd0);
        check("abort_no_late_count", 64'(frame_count2), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
